// File: rtl/cordic_bus_regs_if.sv
// Host bus seen by the CORDIC register front-end: one-cycle read/write strobes,
// registered read data with a matching valid pulse.
interface cordic_bus_regs_if #(
    parameter int p_WIDTH      = 32,
    parameter int p_ADDR_WIDTH = 3
);
    logic [p_ADDR_WIDTH-1:0] bus_addr;
    logic                    bus_wr;
    logic                    bus_rd;
    logic [p_WIDTH-1:0]      bus_wdata;
    logic [p_WIDTH-1:0]      bus_rdata;
    logic                    bus_rvalid;

    modport master (
        output bus_addr, bus_wr, bus_rd, bus_wdata,
        input  bus_rdata, bus_rvalid
    );

    modport slave (
        input  bus_addr, bus_wr, bus_rd, bus_wdata,
        output bus_rdata, bus_rvalid
    );
endinterface

// File: rtl/cordic_bus_regs.sv
// Register front-end for the CORDIC controller: operand/control registers for the host,
// capture of controller write-back and results, sticky host-clearable interrupt.
module cordic_bus_regs #(
    parameter int          p_WIDTH      = 32,
    parameter int          p_ADDR_WIDTH = 3,
    parameter logic [31:0] p_CTRL_RESET = 32'h0001_1FF0
) (
    input  logic               clk,
    input  logic               rst,
    cordic_bus_regs_if.slave   bus,
    output logic [31:0]        ctrl_out,
    output logic [p_WIDTH-1:0] x_in,
    output logic [p_WIDTH-1:0] y_in,
    output logic [p_WIDTH-1:0] z_in,
    input  logic [31:0]        ctrl_in,
    input  logic               ctrl_we,
    input  logic [p_WIDTH-1:0] x_res,
    input  logic [p_WIDTH-1:0] y_res,
    input  logic [p_WIDTH-1:0] z_res,
    input  logic               cordic_int,
    output logic               irq
);
    localparam logic [p_ADDR_WIDTH-1:0] A_CTRL = p_ADDR_WIDTH'(0);
    localparam logic [p_ADDR_WIDTH-1:0] A_XIN  = p_ADDR_WIDTH'(1);
    localparam logic [p_ADDR_WIDTH-1:0] A_YIN  = p_ADDR_WIDTH'(2);
    localparam logic [p_ADDR_WIDTH-1:0] A_ZIN  = p_ADDR_WIDTH'(3);
    localparam logic [p_ADDR_WIDTH-1:0] A_XRES = p_ADDR_WIDTH'(4);
    localparam logic [p_ADDR_WIDTH-1:0] A_YRES = p_ADDR_WIDTH'(5);
    localparam logic [p_ADDR_WIDTH-1:0] A_ZRES = p_ADDR_WIDTH'(6);
    localparam logic [p_ADDR_WIDTH-1:0] A_STAT = p_ADDR_WIDTH'(7);

    logic [31:0]        ctrl_q, ctrl_d;
    logic [p_WIDTH-1:0] x_in_q, x_in_d, y_in_q, y_in_d, z_in_q, z_in_d;
    logic [p_WIDTH-1:0] x_res_q, x_res_d, y_res_q, y_res_d, z_res_q, z_res_d;
    logic               irq_pending_q, irq_pending_d;
    logic               busy_q, busy_d;
    logic [7:0]         done_cnt_q, done_cnt_d;
    logic [p_WIDTH-1:0] rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic               wr_ctrl, wr_x, wr_y, wr_z, wr_stat, done;
    logic [31:0]        status;
    logic [p_WIDTH-1:0] rd_val;

    always_comb begin
        wr_ctrl = bus.bus_wr && (bus.bus_addr == A_CTRL);
        wr_x    = bus.bus_wr && (bus.bus_addr == A_XIN) && !busy_q;
        wr_y    = bus.bus_wr && (bus.bus_addr == A_YIN) && !busy_q;
        wr_z    = bus.bus_wr && (bus.bus_addr == A_ZIN) && !busy_q;
        wr_stat = bus.bus_wr && (bus.bus_addr == A_STAT);
        done    = ctrl_we && ctrl_in[16];

        // Write-back supplies the flag half; a same-cycle bus write owns whatever it may touch.
        ctrl_d = ctrl_we ? ctrl_in : ctrl_q;
        if (wr_ctrl) begin
            if (busy_q) begin
                ctrl_d[1] = bus.bus_wdata[1];
            end else begin
                ctrl_d[15:0] = bus.bus_wdata[15:0];
            end
        end

        x_in_d  = wr_x ? bus.bus_wdata : x_in_q;
        y_in_d  = wr_y ? bus.bus_wdata : y_in_q;
        z_in_d  = wr_z ? bus.bus_wdata : z_in_q;
        x_res_d = done ? x_res : x_res_q;
        y_res_d = done ? y_res : y_res_q;
        z_res_d = done ? z_res : z_res_q;
        done_cnt_d = done ? done_cnt_q + 8'd1 : done_cnt_q;

        // Set wins over clear for both sticky flags.
        busy_d        = (wr_ctrl && bus.bus_wdata[0]) ? 1'b1 : (done ? 1'b0 : busy_q);
        irq_pending_d = cordic_int ? 1'b1 :
                        ((wr_stat && bus.bus_wdata[0]) ? 1'b0 : irq_pending_q);

        status = {16'h0000, done_cnt_q, 6'b000000, busy_q, irq_pending_q};
        case (bus.bus_addr)
            A_CTRL:  rd_val = p_WIDTH'(ctrl_q);
            A_XIN:   rd_val = x_in_q;
            A_YIN:   rd_val = y_in_q;
            A_ZIN:   rd_val = z_in_q;
            A_XRES:  rd_val = x_res_q;
            A_YRES:  rd_val = y_res_q;
            A_ZRES:  rd_val = z_res_q;
            A_STAT:  rd_val = p_WIDTH'(status);
            default: rd_val = '0;
        endcase
        rdata_d  = bus.bus_rd ? rd_val : rdata_q;
        rvalid_d = bus.bus_rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q        <= p_CTRL_RESET;
            x_in_q        <= '0;
            y_in_q        <= '0;
            z_in_q        <= '0;
            x_res_q       <= '0;
            y_res_q       <= '0;
            z_res_q       <= '0;
            irq_pending_q <= 1'b0;
            busy_q        <= 1'b0;
            done_cnt_q    <= 8'd0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            x_in_q        <= x_in_d;
            y_in_q        <= y_in_d;
            z_in_q        <= z_in_d;
            x_res_q       <= x_res_d;
            y_res_q       <= y_res_d;
            z_res_q       <= z_res_d;
            irq_pending_q <= irq_pending_d;
            busy_q        <= busy_d;
            done_cnt_q    <= done_cnt_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    assign ctrl_out       = ctrl_q;
    assign x_in           = x_in_q;
    assign y_in           = y_in_q;
    assign z_in           = z_in_q;
    assign irq            = irq_pending_q;
    assign bus.bus_rdata  = rdata_q;
    assign bus.bus_rvalid = rvalid_q;
endmodule

// File: tb/tb_cordic_bus_regs.sv
// Directed bench for cordic_bus_regs: a table of bus reads/writes followed by
// hand-written sequences for write-back, interrupt, collision, wrap and reset cases.
module tb_cordic_bus_regs;
    localparam int W  = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   ctrlOut, ctrlIn;
    logic [W-1:0]  xIn, yIn, zIn, xRes, yRes, zRes;
    logic          ctrlWe, cordicInt, irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          isWrite;
        logic [2:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t vecs[$];

    cordic_bus_regs_if #(.p_WIDTH(W), .p_ADDR_WIDTH(AW)) bus ();

    cordic_bus_regs #(.p_WIDTH(W), .p_ADDR_WIDTH(AW), .p_CTRL_RESET(32'h0001_1FF0)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ctrl_out(ctrlOut), .x_in(xIn), .y_in(yIn), .z_in(zIn),
        .ctrl_in(ctrlIn), .ctrl_we(ctrlWe),
        .x_res(xRes), .y_res(yRes), .z_res(zRes),
        .cordic_int(cordicInt), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle starting at a negedge and returns at the next negedge with strobes cleared.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] addr,
                                 input logic [31:0] wdata, input logic we,
                                 input logic [31:0] cin, input logic intr);
        bus.bus_wr    = wr;
        bus.bus_rd    = rd;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        ctrlWe        = we;
        ctrlIn        = cin;
        cordicInt     = intr;
        @(negedge clk);
        bus.bus_wr = 1'b0;
        bus.bus_rd = 1'b0;
        ctrlWe     = 1'b0;
        cordicInt  = 1'b0;
    endtask

    task automatic busWrite(input logic [2:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, addr, data, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic busRead(input logic [2:0] addr, input logic [31:0] expected, input string name);
        applyStimulus(1'b0, 1'b1, addr, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput({name, ".rvalid"}, 32'(bus.bus_rvalid), 32'h1);
        checkOutput(name, bus.bus_rdata, expected);
    endtask

    task automatic addVec(input bit w, input logic [2:0] a, input logic [31:0] d, input string n);
        vec_t v;
        v.isWrite = w;
        v.addr    = a;
        v.data    = d;
        v.name    = n;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0;
        bus.bus_wr = 1'b0; bus.bus_rd = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0;
        ctrlWe = 1'b0; ctrlIn = '0; cordicInt = 1'b0;
        xRes = '0; yRes = '0; zRes = '0;

        // Reads right after reset, then operand load and start, then writes while busy.
        addVec(0, 3'd0, 32'h0001_1FF0, "rstCtrl");
        addVec(0, 3'd1, 32'h0, "rstXin");
        addVec(0, 3'd2, 32'h0, "rstYin");
        addVec(0, 3'd3, 32'h0, "rstZin");
        addVec(0, 3'd4, 32'h0, "rstXres");
        addVec(0, 3'd5, 32'h0, "rstYres");
        addVec(0, 3'd6, 32'h0, "rstZres");
        addVec(0, 3'd7, 32'h0, "rstStatus");
        addVec(1, 3'd1, 32'h2000_0000, "");
        addVec(1, 3'd3, 32'h1000_0000, "");
        addVec(1, 3'd2, 32'h0000_0003, "");
        addVec(0, 3'd1, 32'h2000_0000, "loadXin");
        addVec(0, 3'd2, 32'h0000_0003, "loadYin");
        addVec(0, 3'd3, 32'h1000_0000, "loadZin");
        addVec(1, 3'd0, 32'hFFFF_1FFD, "");
        addVec(0, 3'd0, 32'h0001_1FFD, "startCtrl");
        addVec(0, 3'd7, 32'h0000_0002, "startBusy");
        addVec(1, 3'd1, 32'h0000_0005, "");
        addVec(0, 3'd1, 32'h2000_0000, "busyXinKept");
        addVec(1, 3'd7, 32'hFFFF_FFFF, "");
        addVec(0, 3'd7, 32'h0000_0002, "statusRoKept");
        addVec(1, 3'd4, 32'h0000_DEAD, "");
        addVec(0, 3'd4, 32'h0, "xresRoKept");

        #12;
        checkOutput("rstCtrlOut", ctrlOut, 32'h0001_1FF0);
        checkOutput("rstXinOut", xIn, 32'h0);
        checkOutput("rstIrq", 32'(irq), 32'h0);
        checkOutput("rstRvalid", 32'(bus.bus_rvalid), 32'h0);
        checkOutput("rstRdata", bus.bus_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].isWrite) busWrite(vecs[i].addr, vecs[i].data);
            else busRead(vecs[i].addr, vecs[i].data, vecs[i].name);
        end
        checkOutput("startCtrlOut", ctrlOut, 32'h0001_1FFD);
        checkOutput("startXinOut", xIn, 32'h2000_0000);

        // Write-back without ready: CONTROL follows ctrl_in, results are not captured.
        xRes = 32'hAAAA_AAAA;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0000_1FFC, 1'b0);
        busRead(3'd0, 32'h0000_1FFC, "wbCtrl");
        busRead(3'd7, 32'h0000_0002, "wbBusy");
        busRead(3'd4, 32'h0, "wbNoCapture");
        busWrite(3'd0, 32'h0000_0002);
        checkOutput("busyStopOnly", ctrlOut, 32'h0000_1FFE);

        // Completion followed by the interrupt pulse.
        xRes = 32'h1234_5678; yRes = 32'h0BAD_F00D; zRes = 32'h0000_0042;
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0001_1FF0, 1'b0);
        checkOutput("irqBeforePulse", 32'(irq), 32'h0);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("irqAfterPulse", 32'(irq), 32'h1);
        busRead(3'd4, 32'h1234_5678, "doneXres");
        busRead(3'd5, 32'h0BAD_F00D, "doneYres");
        busRead(3'd7, 32'h0000_0101, "doneStatus");
        busRead(3'd0, 32'h0001_1FF0, "doneCtrl");
        busWrite(3'd7, 32'h0000_0001);
        checkOutput("irqCleared", 32'(irq), 32'h0);

        // Read and write of the same register in one cycle returns the old value.
        applyStimulus(1'b1, 1'b1, 3'd2, 32'h0000_0077, 1'b0, 32'h0, 1'b0);
        checkOutput("rwOldValue", bus.bus_rdata, 32'h0000_0003);
        busRead(3'd2, 32'h0000_0077, "rwNewValue");
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rvalidDrops", 32'(bus.bus_rvalid), 32'h0);
        checkOutput("rdataHolds", bus.bus_rdata, 32'h0000_0077);

        applyStimulus(1'b1, 1'b0, 3'd7, 32'h0000_0001, 1'b0, 32'h0, 1'b1);
        checkOutput("irqSetWins", 32'(irq), 32'h1);
        busWrite(3'd7, 32'h0000_0001);
        checkOutput("irqClearAgain", 32'(irq), 32'h0);

        // Write-back in the same cycle as a CONTROL write: upper half from ctrl_in, lower from bus.
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0000_0ABC, 1'b1, 32'h0005_1234, 1'b0);
        checkOutput("ctrlMerge", ctrlOut, 32'h0005_0ABC);
        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0000_0001, 1'b1, 32'h0001_0000, 1'b0);
        checkOutput("busySetCtrl", ctrlOut, 32'h0001_0001);
        busRead(3'd7, 32'h0000_0302, "busySetWins");

        // Counter is at 3; 252 more completions reach 255, one more wraps to 0.
        for (int i = 0; i < 252; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0001_0000, 1'b0);
        end
        busRead(3'd7, 32'h0000_FF00, "cnt255");
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0001_0000, 1'b0);
        busRead(3'd7, 32'h0000_0000, "cntWrap");

        // Asynchronous reset in the middle of an operation.
        busWrite(3'd1, 32'h0000_0055);
        applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1);
        busWrite(3'd0, 32'h0000_0001);
        checkOutput("preRstIrq", 32'(irq), 32'h1);
        checkOutput("preRstXin", xIn, 32'h0000_0055);
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncCtrlOut", ctrlOut, 32'h0001_1FF0);
        checkOutput("asyncXin", xIn, 32'h0);
        checkOutput("asyncIrq", 32'(irq), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        busRead(3'd7, 32'h0000_0000, "postRstStatus");
        busRead(3'd0, 32'h0001_1FF0, "postRstCtrl");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/cordic_bus_regs.md
Name: cordic_bus_regs

Overview:
- Memory-mapped register front-end that sits directly upstream of the CORDIC controller.
- Holds the operand registers (X/Y/Z input) and the control word that the controller samples, and exposes them to the host bus.
- Captures the controller's write-back of the control/flag word and the X/Y/Z results, and turns the controller's one-cycle interrupt pulse into a sticky, host-clearable interrupt line.

Parameters:
p_WIDTH, 32, data/operand width
p_ADDR_WIDTH, 3, word-address width of the register map
p_CTRL_RESET, 32'h0001_1FF0, reset value of CONTROL (ready=1, iterations=31, int/overflow enables=1, start/stop/mode/system=0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
bus_addr  in  p_ADDR_WIDTH  word address
bus_wr  in  1  write strobe, one cycle per write
bus_rd  in  1  read strobe, one cycle per read
bus_wdata  in  p_WIDTH  write data
bus_rdata  out  p_WIDTH  read data, registered
bus_rvalid  out  1  read data valid pulse
ctrl_out  out  32  CONTROL register to controller (controlRegisterInput)
x_in / y_in / z_in  out  p_WIDTH each  operands to controller
ctrl_in  in  32  control/flag word from controller (controlRegisterOutput)
ctrl_we  in  1  controller write-back enable
x_res / y_res / z_res  in  p_WIDTH each  controller results
cordic_int  in  1  controller interrupt pulse
irq  out  1  sticky interrupt to host

Behaviour:
- Reset (rst=0, asynchronous):
  - CONTROL=p_CTRL_RESET.
  - X_IN/Y_IN/Z_IN/X_RES/Y_RES/Z_RES=0.
  - irq_pending=0, busy=0, done_cnt=0.
  - bus_rdata=0, bus_rvalid=0, irq=0.
- Register map (word address):
  - 0 CONTROL: lower 16 bits RW, upper 16 bits RO flags.
  - 1 X_IN, 2 Y_IN, 3 Z_IN: RW.
  - 4 X_RES, 5 Y_RES, 6 Z_RES: RO.
  - 7 STATUS: bit0 irq_pending (write-1-to-clear), bit1 busy (RO), bits[15:8] done_cnt (RO), other bits read 0.
  - Writes to RO fields are ignored.
- Read: bus_rd at cycle N produces bus_rvalid=1 and bus_rdata=value at N+1; otherwise bus_rvalid=0 and bus_rdata holds its last value.
- Read/write collision: a read and a write in the same cycle return the pre-write value.
- busy flag:
  - Set on an accepted CONTROL write with wdata[0]=1.
  - Cleared on ctrl_we=1 with ctrl_in[16]=1 (ready).
  - A simultaneous set and clear leaves busy set.
- Writes while busy=1:
  - X_IN/Y_IN/Z_IN writes are ignored.
  - CONTROL writes update only bit1 (stop); all other bits are unchanged.
- Writes while busy=0: CONTROL[15:0] is fully writable.
- Start bit: CONTROL[0] stays 1 until the controller's write-back clears it; this block never self-clears it.
- Controller write-back (ctrl_we=1):
  - CONTROL loads all 32 bits of ctrl_in.
  - If an accepted bus write to CONTROL occurs in the same cycle, bits[15:0] come from the bus write and bits[31:16] from ctrl_in.
- Result capture: on ctrl_we=1 with ctrl_in[16]=1:
  - X_RES/Y_RES/Z_RES load x_res/y_res/z_res.
  - done_cnt increments, wrapping 255->0.
  - Results are never captured while ctrl_in[16]=0.
- Interrupt:
  - cordic_int=1 sets irq_pending at the next edge.
  - A STATUS write with wdata[0]=1 clears irq_pending.
  - A simultaneous set and clear leaves irq_pending set.
  - irq = irq_pending (registered, no combinational path from cordic_int).
- Outputs: ctrl_out, x_in, y_in, z_in are direct register outputs.
- Reset mid-operation returns all state to reset values immediately; busy drops with it.

Test Plan:
1. Reset: hold rst=0 -> ctrl_out=32'h0001_1FF0, all reads return 0 except CONTROL, irq=0, bus_rvalid=0.
2. Operand load and start:
   - Stimulus: write X_IN=32'h2000_0000, Z_IN=32'h1000_0000, then CONTROL=32'h0000_1FFD.
   - Response: ctrl_out[0]=1, x_in=32'h2000_0000, STATUS.busy=1.
   - Then ctrl_we with ctrl_in=32'h0000_1FFC: CONTROL reads 32'h0000_1FFC, busy stays 1.
3. Writes while busy:
   - Stimulus: with busy=1, write X_IN=5, then CONTROL=32'h0000_0002.
   - Response: X_IN unchanged; ctrl_out[1]=1, ctrl_out[0] and other lower bits unchanged.
4. Completion:
   - Stimulus: ctrl_we with ctrl_in[16]=1, x_res=32'h1234_5678; cordic_int pulse the next cycle.
   - Response: X_RES=32'h1234_5678, done_cnt=1, busy=0, irq=1 one cycle after the pulse.
   - Then STATUS write 1: irq=0.
5. Collisions:
   - cordic_int=1 in the same cycle as a STATUS W1C -> irq remains 1.
   - ctrl_we in the same cycle as a CONTROL write -> upper 16 bits from ctrl_in, lower 16 bits from the bus.
6. Wrap and mid-operation reset:
   - 256 completions -> done_cnt=0.
   - Assert rst mid-operation -> busy=0, ctrl_out=32'h0001_1FF0 without waiting for a clock edge.
